mmio_controller: RTL and testbench

//  Parametrised eLC-3 memory/IO controller between the CPU memory port, the SRAM chip, keyboard and video.

---
 rtl/mmio_pkg.sv | 29 ++
 rtl/kbd_fifo.sv | 62 ++++++
 rtl/mmio_controller.sv | 217 +++++++++++++++++++++
 tb/tb_mmio_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the eLC-3 memory/IO controller.
//   - IO register offsets within the 256-word IO window
//   - KBSR / DSR bit positions
//   - access FSM state encoding
package mmio_pkg;

   // Register offsets, relative to the IO window base (Address[7:0])
   localparam logic [7:0] OFF_KBSR = 8'h00;
   localparam logic [7:0] OFF_KBDR = 8'h02;
   localparam logic [7:0] OFF_DSR  = 8'h04;
   localparam logic [7:0] OFF_DDR  = 8'h06;

   // KBSR bit indices
   localparam int unsigned KBSR_READY = 15;
   localparam int unsigned KBSR_IE    = 14;
   localparam int unsigned KBSR_OVF   = 13;

   // DSR bit index
   localparam int unsigned DSR_READY  = 15;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IO   = 2'd1,
      SRAM = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: synchronous keystroke FIFO, DATA_W x DEPTH (DEPTH power of 2, >= 2).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write strobe and data; ignored when full unless popping in the same cycle
//   pop        read strobe; ignored when empty
//   full       DEPTH entries held
//   empty      no entries held
//   head       oldest entry (valid while !empty)
module kbd_fifo
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 8
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic              full,
   output logic              empty,
   output logic [DATA_W-1:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   // A full FIFO still accepts a push when an entry leaves in the same cycle
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mmio_controller.sv
// mmio_controller: eLC-3 memory/IO controller between the CPU memory port,
// the SRAM chip, the keyboard and the video output.
//   - IO window of 256 words at IO_BASE: KBSR(+0) KBDR(+2) DSR(+4) DDR(+6)
//   - keystrokes buffered in a KBD_FIFO_DEPTH-entry FIFO with sticky overflow
//   - MIO_EN / Mem_Ready handshake, SRAM accesses stretched by MEM_WAIT cycles
// Ports:
//   Clk, Reset               clock, asynchronous active-high reset
//   MIO_EN, R_W, Address     CPU request (held until Mem_Ready), 1 = write
//   Data_FromCPU             CPU write data (also driven to SRAM)
//   Data_FromSRAM            SRAM read data
//   Data_FromKeyboard        keycode, 0 = no key
//   Keypress                 key strobe level, one push per rising edge
//   DisplayReady             pulse: video consumed DDR
//   Mem_CE/OE/WE/LB/UB       SRAM controls, active-high
//   Data_ToSRAM              SRAM write data
//   Data_ToCPU               registered read data, held until next read
//   Data_ToVideo             current DDR
//   Mem_Ready                one-cycle completion pulse
//   Kbd_Irq                  keyboard interrupt (only with MMIO_KBD_IRQ_EN)
// Configuration macro: MMIO_KBD_IRQ_EN enables the KBSR interrupt-enable bit
// and the Kbd_Irq output; without it KBSR[14] reads 0 and ignores writes.
module mmio_controller
   import mmio_pkg::*;
#(
   parameter int unsigned       DATA_W         = 16,
   parameter int unsigned       ADDR_W         = 16,
   parameter logic [ADDR_W-1:0] IO_BASE        = ADDR_W'(16'hFE00),
   parameter int unsigned       KBD_FIFO_DEPTH = 8,
   parameter int unsigned       MEM_WAIT       = 1
)
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic              MIO_EN,
   input  logic              R_W,
   input  logic [ADDR_W-1:0] Address,
   input  logic [DATA_W-1:0] Data_FromCPU,
   input  logic [DATA_W-1:0] Data_FromSRAM,
   input  logic [DATA_W-1:0] Data_FromKeyboard,
   input  logic              Keypress,
   input  logic              DisplayReady,
   output logic              Mem_CE,
   output logic              Mem_OE,
   output logic              Mem_WE,
   output logic              Mem_LB,
   output logic              Mem_UB,
   output logic [DATA_W-1:0] Data_ToSRAM,
   output logic [DATA_W-1:0] Data_ToCPU,
   output logic [DATA_W-1:0] Data_ToVideo,
   output logic              Mem_Ready
`ifdef MMIO_KBD_IRQ_EN
   ,output logic             Kbd_Irq
`endif
);

   state_t            state;
   logic [3:0]        wait_cnt;
   logic              in_io;
   logic [7:0]        offset;
   logic              io_rd;
   logic              io_wr;
   logic              key_prev;
   logic              key_push;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              ovf;
   logic              ie;
   logic              disp_ready;
   logic [DATA_W-1:0] ddr;
   logic [DATA_W-1:0] rd_data;

   assign in_io  = (Address[ADDR_W-1:8] == IO_BASE[ADDR_W-1:8]);
   assign offset = Address[7:0];

   // Register side effects happen only on the single IO-state edge, so a
   // CPU that holds MIO_EN through DONE cannot pop KBDR twice.
   assign io_rd  = (state == IO) & ~R_W;
   assign io_wr  = (state == IO) &  R_W;

   assign key_push  = Keypress & ~key_prev & (Data_FromKeyboard != '0);
   assign fifo_pop  = io_rd & (offset == OFF_KBDR) & ~fifo_empty;
   assign fifo_push = key_push;

   assign Data_ToSRAM  = Data_FromCPU;
   assign Data_ToVideo = ddr;

   kbd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (KBD_FIFO_DEPTH)
   ) u_kbd_fifo (
      .clk   (Clk),
      .rst   (Reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (Data_FromKeyboard),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // IO read data; unmapped offsets and the write-only DDR read as zero
   always_comb begin
      rd_data = '0;
      case (offset)
         OFF_KBSR: begin
            rd_data[KBSR_READY] = ~fifo_empty;
            rd_data[KBSR_IE]    = ie;
            rd_data[KBSR_OVF]   = ovf;
         end
         OFF_KBDR: begin
            if (!fifo_empty) rd_data = fifo_head;
         end
         OFF_DSR: begin
            rd_data[DSR_READY] = disp_ready;
         end
         default: rd_data = '0;
      endcase
   end

   // Keyboard status, display status and DDR
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         key_prev   <= 1'b0;
         ovf        <= 1'b0;
         disp_ready <= 1'b1;
         ddr        <= '0;
      end else begin
         key_prev <= Keypress;
         // A fresh loss outranks a same-cycle clear so it is never hidden
         if (key_push && fifo_full && !fifo_pop)
            ovf <= 1'b1;
         else if (io_wr && offset == OFF_KBSR && Data_FromCPU[KBSR_OVF])
            ovf <= 1'b0;
         if (io_wr && offset == OFF_DDR) begin
            ddr        <= Data_FromCPU;
            disp_ready <= 1'b0;
         end else if (DisplayReady) begin
            disp_ready <= 1'b1;
         end
      end
   end

`ifdef MMIO_KBD_IRQ_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         ie      <= 1'b0;
         Kbd_Irq <= 1'b0;
      end else begin
         if (io_wr && offset == OFF_KBSR) ie <= Data_FromCPU[KBSR_IE];
         Kbd_Irq <= ie & ~fifo_empty;
      end
   end
`else
   assign ie = 1'b0;
`endif

   // Access sequencer with registered SRAM strobes and completion pulse
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         Mem_CE     <= 1'b0;
         Mem_OE     <= 1'b0;
         Mem_WE     <= 1'b0;
         Mem_LB     <= 1'b0;
         Mem_UB     <= 1'b0;
         Mem_Ready  <= 1'b0;
         Data_ToCPU <= '0;
      end else begin
         Mem_Ready <= 1'b0;
         case (state)
            IDLE: begin
               if (MIO_EN) begin
                  if (in_io) begin
                     state <= IO;
                  end else begin
                     state    <= SRAM;
                     wait_cnt <= 4'(MEM_WAIT);
                     Mem_CE   <= 1'b1;
                     Mem_LB   <= 1'b1;
                     Mem_UB   <= 1'b1;
                     Mem_OE   <= ~R_W;
                     Mem_WE   <= R_W;
                  end
               end
            end
            IO: begin
               if (!R_W) Data_ToCPU <= rd_data;
               Mem_Ready <= 1'b1;
               state     <= DONE;
            end
            SRAM: begin
               if (wait_cnt == '0) begin
                  if (!R_W) Data_ToCPU <= Data_FromSRAM;
                  Mem_CE    <= 1'b0;
                  Mem_LB    <= 1'b0;
                  Mem_UB    <= 1'b0;
                  Mem_OE    <= 1'b0;
                  Mem_WE    <= 1'b0;
                  Mem_Ready <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            DONE: begin
               if (!MIO_EN) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed bench for mmio_controller with a read-data
// scoreboard fed by the stimulus and drained by a Mem_Ready monitor.
module tb_mmio_controller;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        MIO_EN = 1'b0;
   logic        R_W = 1'b0;
   logic [15:0] Address = '0;
   logic [15:0] Data_FromCPU = '0;
   logic [15:0] Data_FromSRAM = 16'hBEEF;
   logic [15:0] Data_FromKeyboard = '0;
   logic        Keypress = 1'b0;
   logic        DisplayReady = 1'b0;
   logic        Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB;
   logic [15:0] Data_ToSRAM, Data_ToCPU, Data_ToVideo;
   logic        Mem_Ready;
`ifdef MMIO_KBD_IRQ_EN
   logic        Kbd_Irq;
`endif

   int checks = 0;
   int errors = 0;
   int last_lat, last_oe, last_we, last_ce;

   typedef struct {
      logic        is_read;
      logic [15:0] data;
      string       name;
   } exp_t;
   exp_t sb[$];

   mmio_controller #(
      .DATA_W         (16),
      .ADDR_W         (16),
      .IO_BASE        (16'hFE00),
      .KBD_FIFO_DEPTH (8),
      .MEM_WAIT       (1)
   ) dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .MIO_EN            (MIO_EN),
      .R_W               (R_W),
      .Address           (Address),
      .Data_FromCPU      (Data_FromCPU),
      .Data_FromSRAM     (Data_FromSRAM),
      .Data_FromKeyboard (Data_FromKeyboard),
      .Keypress          (Keypress),
      .DisplayReady      (DisplayReady),
      .Mem_CE            (Mem_CE),
      .Mem_OE            (Mem_OE),
      .Mem_WE            (Mem_WE),
      .Mem_LB            (Mem_LB),
      .Mem_UB            (Mem_UB),
      .Data_ToSRAM       (Data_ToSRAM),
      .Data_ToCPU        (Data_ToCPU),
      .Data_ToVideo      (Data_ToVideo),
      .Mem_Ready         (Mem_Ready)
`ifdef MMIO_KBD_IRQ_EN
      ,.Kbd_Irq          (Kbd_Irq)
`endif
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every Mem_Ready pulse consumes one expectation
   always @(negedge Clk) begin
      if (!Reset && Mem_Ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: got Mem_Ready=1 expected no pending access");
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.is_read) check(e.name, {16'h0, Data_ToCPU}, {16'h0, e.data});
         end
      end
   end

   task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] exp, input string name,
                         input logic dr_pulse, input logic key_pulse, input logic [15:0] key);
      exp_t e;
      bit   got;
      e.is_read = ~rw;
      e.data    = exp;
      e.name    = name;
      sb.push_back(e);
      Address = addr;
      R_W = rw;
      Data_FromCPU = wdata;
      MIO_EN = 1'b1;
      last_lat = 0; last_oe = 0; last_we = 0; last_ce = 0;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge Clk); #1;
         last_lat++;
         if (i == 0) begin
            if (dr_pulse) DisplayReady = 1'b1;
            if (key_pulse) begin
               Data_FromKeyboard = key;
               Keypress = 1'b1;
            end
         end else begin
            DisplayReady = 1'b0;
            Keypress = 1'b0;
         end
         if (Mem_OE) last_oe++;
         if (Mem_WE) last_we++;
         if (Mem_CE) last_ce++;
         if (Mem_Ready) got = 1;
      end
      DisplayReady = 1'b0;
      Keypress = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: got no Mem_Ready expected completion", name);
         void'(sb.pop_back());
      end
      MIO_EN = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string name);
      access(1'b0, addr, 16'h0, exp, name, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data, input string name);
      access(1'b1, addr, data, 16'h0, name, 1'b0, 1'b0, 16'h0);
   endtask

   task automatic key(input logic [15:0] code);
      Data_FromKeyboard = code;
      Keypress = 1'b1;
      @(posedge Clk); #1;
      Keypress = 1'b0;
      @(posedge Clk); #1;
   endtask

   initial begin
      repeat (3) @(posedge Clk);
      #1;
      check("rst_ready",  {31'h0, Mem_Ready}, 32'h0);
      check("rst_ce",     {31'h0, Mem_CE}, 32'h0);
      check("rst_tocpu",  {16'h0, Data_ToCPU}, 32'h0);
      check("rst_video",  {16'h0, Data_ToVideo}, 32'h0);
      Reset = 1'b0;
      @(posedge Clk); #1;

      // SRAM read/write with one wait state
      rd(16'h3000, 16'hBEEF, "sram_rd_data");
      check("sram_rd_latency", last_lat, 3);
      check("sram_rd_oe_cycles", last_oe, 2);
      check("sram_rd_ce_cycles", last_ce, 2);
      check("sram_rd_we_cycles", last_we, 0);
      wr(16'h3001, 16'h1234, "sram_wr");
      check("sram_wr_we_cycles", last_we, 2);
      check("sram_wr_oe_cycles", last_oe, 0);
      check("sram_wr_keeps_tocpu", {16'h0, Data_ToCPU}, 32'hBEEF);
      check("sram_wr_tosram", {16'h0, Data_ToSRAM}, 32'h1234);

      // Unmapped IO offset: zero, no SRAM cycle, single IO cycle
      rd(16'hFE08, 16'h0000, "unmapped_rd");
      check("unmapped_ce_cycles", last_ce, 0);
      check("io_latency", last_lat, 2);

      // Two keystrokes
      key(16'h0041);
      key(16'h0042);
      rd(16'hFE00, 16'h8000, "kbsr_two_keys");
      rd(16'hFE02, 16'h0041, "kbdr_first");
      rd(16'hFE02, 16'h0042, "kbdr_second");
      rd(16'hFE00, 16'h0000, "kbsr_drained");
      rd(16'hFE02, 16'h0000, "kbdr_empty");

      // Overflow on the ninth key
      for (int k = 1; k <= 9; k++) key(16'(k));
      rd(16'hFE00, 16'hA000, "kbsr_overflow");
      wr(16'hFE00, 16'h2000, "kbsr_clr_ovf");
      rd(16'hFE00, 16'h8000, "kbsr_ovf_cleared");
      for (int k = 1; k <= 8; k++) rd(16'hFE02, 16'(k), "kbdr_drain");
      rd(16'hFE02, 16'h0000, "kbdr_ninth_lost");

      // Display data path
      wr(16'hFE06, 16'h0058, "ddr_wr");
      check("video_ddr", {16'h0, Data_ToVideo}, 32'h0058);
      rd(16'hFE04, 16'h0000, "dsr_busy");
      DisplayReady = 1'b1;
      @(posedge Clk); #1;
      DisplayReady = 1'b0;
      rd(16'hFE04, 16'h8000, "dsr_ready");

      // DDR write racing DisplayReady: clear wins
      access(1'b1, 16'hFE06, 16'h0059, 16'h0, "ddr_wr_race", 1'b1, 1'b0, 16'h0);
      rd(16'hFE04, 16'h0000, "dsr_race_clear");
      check("video_ddr_race", {16'h0, Data_ToVideo}, 32'h0059);

      // Pop and push in the same cycle
      key(16'h0061);
      key(16'h0062);
      access(1'b0, 16'hFE02, 16'h0, 16'h0061, "kbdr_pop_push", 1'b0, 1'b1, 16'h0063);
      rd(16'hFE02, 16'h0062, "kbdr_after_pp_1");
      rd(16'hFE02, 16'h0063, "kbdr_after_pp_2");
      rd(16'hFE02, 16'h0000, "kbdr_after_pp_empty");
      // Pop from empty with a push: push proceeds
      access(1'b0, 16'hFE02, 16'h0, 16'h0000, "kbdr_empty_push", 1'b0, 1'b1, 16'h0064);
      rd(16'hFE02, 16'h0064, "kbdr_after_empty_push");

      // Zero keycode is not a keystroke
      key(16'h0000);
      rd(16'hFE00, 16'h0000, "kbsr_zero_key");

`ifdef MMIO_KBD_IRQ_EN
      wr(16'hFE00, 16'h4000, "kbsr_ie_on");
      check("irq_idle", {31'h0, Kbd_Irq}, 32'h0);
      key(16'h0071);
      check("irq_after_push", {31'h0, Kbd_Irq}, 32'h1);
      rd(16'hFE00, 16'hC000, "kbsr_ie_ready");
      rd(16'hFE02, 16'h0071, "kbdr_irq_key");
      check("irq_after_pop", {31'h0, Kbd_Irq}, 32'h0);
`else
      wr(16'hFE00, 16'h4000, "kbsr_ie_ignored");
      rd(16'hFE00, 16'h0000, "kbsr_ie_reads_zero");
`endif

      // Reset in the middle of an SRAM access
      Address = 16'h3000;
      R_W = 1'b0;
      MIO_EN = 1'b1;
      @(posedge Clk); #1;
      check("midrst_ce_before", {31'h0, Mem_CE}, 32'h1);
      Reset = 1'b1;
      #1;
      check("midrst_ce_dropped", {31'h0, Mem_CE}, 32'h0);
      check("midrst_oe_dropped", {31'h0, Mem_OE}, 32'h0);
      check("midrst_tocpu", {16'h0, Data_ToCPU}, 32'h0);
      MIO_EN = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      check("midrst_video", {16'h0, Data_ToVideo}, 32'h0);
      rd(16'hFE04, 16'h8000, "dsr_after_reset");
      rd(16'hFE00, 16'h0000, "kbsr_after_reset");

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge Clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
